// File: rtl/mul_div_unit.sv
// mul_div_unit: 32-bit HI/LO multiply/divide unit.
//   MULT/MULTU write the 64-bit product to {hi,lo} in one cycle.
//   MTHI/MTLO copy rs1_data into hi or lo in one cycle.
//   DIV/DIVU run a 32-step restoring divider on operand magnitudes,
//   then a sign-fix step writes lo=quotient, hi=remainder.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   start     - operation request, honoured only while idle
//   op        - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO (6,7 ignored)
//   rs1_data  - operand A (multiplicand / dividend / move source)
//   rs2_data  - operand B (multiplier / divisor)
//   busy      - high while a division is running
//   done      - one-cycle pulse after an operation completes
//   hi, lo    - architectural HI/LO registers
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_e;

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  // Divider datapath (no reset: always reloaded on acceptance)
  logic [DATA_W-1:0]   quot_q;
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   dvsr_q;
  logic [DATA_W-1:0]   dvnd_q;
  logic                q_neg_q;
  logic                r_neg_q;
  logic                dz_q;

  logic                accept;
  logic                op_is_div;
  logic                op_signed;
  logic signed [63:0]  a_sx, b_sx, prod_s;
  logic [63:0]         prod_u;
  logic [DATA_W:0]     shift, diff;
  logic                borrow;

  function automatic logic [DATA_W-1:0] abs32(input logic signed [DATA_W-1:0] v);
    // Magnitude of the most negative value wraps to itself, which is
    // the correct unsigned magnitude 2^31.
    abs32 = v[DATA_W-1] ? DATA_W'(-v) : DATA_W'(v);
  endfunction

  function automatic logic [DATA_W-1:0] neg_if(input logic n, input logic [DATA_W-1:0] v);
    neg_if = n ? DATA_W'(-v) : v;
  endfunction

  assign op_is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign op_signed = (op == OP_DIV);
  assign accept    = start && (state_q == S_IDLE) && (op <= OP_MTLO);

  assign a_sx   = {{32{rs1_data[31]}}, rs1_data};
  assign b_sx   = {{32{rs2_data[31]}}, rs2_data};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, rs1_data} * {32'd0, rs2_data};

  // One restoring step: remainder is always below the divisor, so the
  // shifted value fits in 33 bits and diff[32] is the borrow.
  assign shift  = {rem_q, quot_q[DATA_W-1]};
  assign diff   = shift - {1'b0, dvsr_q};
  assign borrow = diff[DATA_W];

  // State register and architectural registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE: if (accept && op_is_div) state_d = S_ITER;
      S_ITER: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // HI/LO and done next-state
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    if (accept) begin
      case (op)
        OP_MULT:  begin {hi_d, lo_d} = prod_s; done_d = 1'b1; end
        OP_MULTU: begin {hi_d, lo_d} = prod_u; done_d = 1'b1; end
        OP_MTHI:  begin hi_d = rs1_data;       done_d = 1'b1; end
        OP_MTLO:  begin lo_d = rs1_data;       done_d = 1'b1; end
        default:  ;
      endcase
    end
    if (state_q == S_FIX) begin
      done_d = 1'b1;
      if (dz_q) begin
        lo_d = '1;
        hi_d = dvnd_q;
      end else begin
        lo_d = neg_if(q_neg_q, quot_q);
        hi_d = neg_if(r_neg_q, rem_q);
      end
    end
  end

  // Outputs
  always_comb begin
    busy = (state_q != S_IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

  // Divider datapath
  always_ff @(posedge clk) begin
    if (accept && op_is_div) begin
      quot_q  <= op_signed ? abs32(rs1_data) : rs1_data;
      dvsr_q  <= op_signed ? abs32(rs2_data) : rs2_data;
      rem_q   <= '0;
      dvnd_q  <= rs1_data;
      dz_q    <= (rs2_data == '0);
      q_neg_q <= op_signed && (rs1_data[31] ^ rs2_data[31]);
      r_neg_q <= op_signed && rs1_data[31];
    end else if (state_q == S_ITER) begin
      rem_q  <= borrow ? shift[DATA_W-1:0] : diff[DATA_W-1:0];
      quot_q <= {quot_q[DATA_W-2:0], ~borrow};
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  mul_div_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          at;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks    = 0;
  int failures  = 0;
  int done_seen = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      done_seen++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no completion", cyc);
      end else begin
        e = sb.pop_front();
        check32({e.name, "_hi"}, hi, e.hi);
        check32({e.name, "_lo"}, lo, e.lo);
        check32({e.name, "_cycle"}, cyc, e.at);
      end
    end
  end

  // Called at a negedge; the following posedge is the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_done, input logic [31:0] eh, input logic [31:0] el,
                       input string nm);
    exp_t e;
    if (expect_done) begin
      e.hi = eh;
      e.lo = el;
      e.at = cyc + 1 + (((o == 3'd2) || (o == 3'd3)) ? 33 : 0);
      e.name = nm;
      sb.push_back(e);
    end
    op = o;
    rs1_data = a;
    rs2_data = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rs1_data = 32'hDEADBEEF;
    rs2_data = 32'h0BADF00D;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: %0d results outstanding, expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  initial begin : main
    int busy_hi;
    int hold_bad;
    int seen0;

    // Reset state
    repeat (2) @(negedge clk);
    check32("rst_hi", hi, 32'd0);
    check32("rst_lo", lo, 32'd0);
    check32("rst_busy", {31'd0, busy}, 32'd0);
    check32("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single-cycle operations
    issue(3'd0, 32'hFFFFFFFF, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult");
    check32("mult_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    issue(3'd1, 32'hFFFFFFFF, 32'd2, 1, 32'h00000001, 32'hFFFFFFFE, "multu");
    issue(3'd4, 32'h12345678, 32'd0, 1, 32'h12345678, 32'hFFFFFFFE, "mthi");
    issue(3'd5, 32'hCAFEF00D, 32'd0, 1, 32'h12345678, 32'hCAFEF00D, "mtlo");
    drain("single");

    // Reserved op is ignored
    issue(3'd6, 32'h11111111, 32'h22222222, 0, 32'd0, 32'd0, "rsv6");
    issue(3'd7, 32'h33333333, 32'h44444444, 0, 32'd0, 32'd0, "rsv7");
    repeat (2) @(negedge clk);
    check32("rsv_busy", {31'd0, busy}, 32'd0);
    check32("rsv_hi", hi, 32'h12345678);
    check32("rsv_lo", lo, 32'hCAFEF00D);

    // DIV -7/2: 33 busy cycles, hi/lo held until the result
    issue(3'd2, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2");
    busy_hi = 0;
    hold_bad = 0;
    for (int i = 0; i < 33; i++) begin
      if (busy === 1'b1) busy_hi++;
      if (hi !== 32'h12345678 || lo !== 32'hCAFEF00D) hold_bad++;
      @(negedge clk);
    end
    check32("div_busy_cycles", busy_hi, 32'd33);
    check32("div_hold_violations", hold_bad, 32'd0);
    check32("div_busy_after", {31'd0, busy}, 32'd0);
    drain("div1");

    // DIVU by zero, then DIV overflow accepted back-to-back in the done cycle
    issue(3'd3, 32'd100, 32'd0, 1, 32'h00000064, 32'hFFFFFFFF, "divu_by0");
    repeat (33) @(negedge clk);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000, "div_ovf");
    drain("div2");

    // More signed/unsigned and divide-by-zero vectors
    issue(3'd2, 32'd100, 32'hFFFFFFF9, 1, 32'h00000002, 32'hFFFFFFF2, "div_100_m7");
    drain("div3");
    issue(3'd2, 32'hFFFFFF9C, 32'd7, 1, 32'hFFFFFFFE, 32'hFFFFFFF2, "div_m100_7");
    drain("div4");
    issue(3'd3, 32'hFFFFFFF9, 32'd2, 1, 32'h00000001, 32'h7FFFFFFC, "divu_big");
    drain("div5");
    issue(3'd2, 32'hFFFFFFF9, 32'd0, 1, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_neg_by0");
    drain("div6");

    // Start while busy is ignored
    issue(3'd3, 32'd100, 32'd7, 1, 32'd2, 32'd14, "divu_100_7");
    repeat (4) @(negedge clk);
    op = 3'd0;
    rs1_data = 32'h00000003;
    rs2_data = 32'h00000005;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("div7");

    // Reset aborts a running division
    issue(3'd2, 32'd1000, 32'd3, 0, 32'd0, 32'd0, "div_abort");
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check32("abort_busy", {31'd0, busy}, 32'd0);
    check32("abort_hi", hi, 32'd0);
    check32("abort_lo", lo, 32'd0);
    seen0 = done_seen;
    repeat (40) @(negedge clk);
    check32("abort_no_done", done_seen, seen0);

    // Reset wins over start in the same cycle
    issue(3'd4, 32'hA5A5A5A5, 32'd0, 1, 32'hA5A5A5A5, 32'd0, "mthi2");
    drain("mthi2");
    rst = 1'b1;
    op = 3'd0;
    rs1_data = 32'h00000007;
    rs2_data = 32'h00000009;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check32("rstprio_hi", hi, 32'd0);
    check32("rstprio_lo", lo, 32'd0);
    check32("rstprio_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check32("rstprio_done2", {31'd0, done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameters: none; all datapaths SHALL be fixed at 32 bits.
REQ-002 clk  input  1  Single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  Synchronous, active-high reset; SHALL be sampled on the rising edge of clk.
REQ-004 start  input  1  SHALL request an operation; sampled only when busy=0.
REQ-005 op  input  3  SHALL select the operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved.
REQ-006 rs1_data  input  32  SHALL carry the operand A (multiplicand/dividend/move source), driven from the register file rs1 read port.
REQ-007 rs2_data  input  32  SHALL carry the operand B (multiplier/divisor), driven from the register file rs2 read port.
REQ-008 busy  output  1  SHALL be high while a division is in progress.
REQ-009 done  output  1  SHALL be a one-cycle pulse marking a completed operation.
REQ-010 hi  output  32  SHALL present the HI architectural register (registered).
REQ-011 lo  output  32  SHALL present the LO architectural register (registered).

Function
REQ-012 Operands SHALL be captured at the accepting edge E (start=1, busy=0, op<=5); later changes on rs1_data/rs2_data SHALL have no effect.
REQ-013 MULT/MULTU: {hi,lo} SHALL take the 64-bit signed/unsigned product at edge E; done=1 in the cycle after E; busy stays 0.
REQ-014 MTHI/MTLO: hi (resp. lo) SHALL take rs1_data at edge E; the other register SHALL be unchanged; done=1 in the cycle after E.
REQ-015 DIV/DIVU: busy SHALL be 1 from the cycle after E until the result is written; 32 iteration edges (E+1..E+32) of a restoring shift-subtract divider on magnitudes SHALL be followed by one sign-fix edge E+33.
REQ-016 Division result SHALL be written at E+33: lo=quotient, hi=remainder; busy=0 and done=1 in the cycle after E+33.
REQ-017 hi/lo SHALL hold their previous values during E+1..E+32 (no partial updates).
REQ-018 Signed division SHALL truncate toward zero; remainder sign SHALL equal dividend sign.
REQ-019 Divisor zero (DIV or DIVU): lo SHALL be 32'hFFFFFFFF, hi SHALL be the dividend; latency unchanged (33 edges).
REQ-020 DIV 32'h80000000 / 32'hFFFFFFFF: lo SHALL be 32'h80000000, hi SHALL be 0.
REQ-021 start while busy=1 SHALL be ignored (no queueing, no effect on the running division).
REQ-022 Reserved op (6,7) with start SHALL be ignored: no done, no busy, hi/lo unchanged.
REQ-023 State machine: IDLE -> DIV_ITER (DIV/DIVU accepted) -> DIV_FIX (after 32nd iteration) -> IDLE; single-cycle ops SHALL remain in IDLE.
REQ-024 A new operation SHALL be accepted in the same cycle in which done=1 (back-to-back allowed).

Reset
REQ-025 rst=1 SHALL force state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0 at the next edge.
REQ-026 Reset during a division SHALL abort it; no done pulse SHALL follow and hi/lo SHALL read 0.
REQ-027 rst SHALL take priority over start in the same cycle.

Verification
REQ-028 MULT rs1=32'hFFFFFFFF, rs2=2 -> next cycle hi=32'hFFFFFFFF, lo=32'hFFFFFFFE, done=1 for one cycle.
REQ-029 MULTU same operands -> hi=32'h00000001, lo=32'hFFFFFFFE; then MTHI rs1=32'h12345678 -> hi=32'h12345678, lo unchanged.
REQ-030 DIV rs1=-7 (32'hFFFFFFF9), rs2=2 -> busy 33 cycles, then lo=32'hFFFFFFFD, hi=32'hFFFFFFFF, done pulse exactly in the cycle after E+33; hi/lo unchanged before then.
REQ-031 DIVU rs1=100, rs2=0 -> lo=32'hFFFFFFFF, hi=32'h00000064; DIV 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-032 DIVU 100/7 started; start with MULT asserted at E+5 -> ignored; result lo=14, hi=2.
REQ-033 DIV started, rst=1 at E+10 -> busy=0, hi=lo=0 next cycle, no done for 40 following cycles.
